// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the decoder channel-select scanner.
package decoder_scan_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CODE_W = 3;

    localparam logic [CODE_W-1:0] FIRST_UP = 3'd0;
    localparam logic [CODE_W-1:0] FIRST_DN = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sel_next_finder.sv
// Finds the nearest enabled channel from a starting code in the given direction.
module sel_next_finder
    import decoder_scan_pkg::*;
(
    input  logic [CODE_W-1:0] i_cur,
    input  logic              i_dir,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic              i_incl,
    output logic [CODE_W-1:0] o_code,
    output logic              o_found
);

    logic [CODE_W-1:0] w_idx;
    logic              w_beyond;

    // Candidates are visited in sweep order so the first hit is the nearest one.
    always_comb begin
        o_code   = i_cur;
        o_found  = 1'b0;
        w_idx    = '0;
        w_beyond = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_idx = i_dir ? CODE_W'(NUM_CH - 1 - i) : CODE_W'(i);
            if (i_dir) begin
                w_beyond = i_incl ? (w_idx <= i_cur) : (w_idx < i_cur);
            end else begin
                w_beyond = i_incl ? (w_idx >= i_cur) : (w_idx > i_cur);
            end
            if (!o_found && w_beyond && !i_mask[w_idx]) begin
                o_code  = w_idx;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_sel_scanner.sv
// Sweeps 3-bit select codes for the downstream 3-to-8 decoder with dwell, skip mask and wrap.
module decoder_sel_scanner
    import decoder_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  skip_mask,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               sel_valid,
    output logic               busy,
    output logic               done
);

    scan_state_e        r_state;
    logic [CODE_W-1:0]  r_code;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_mode;
    logic               r_dir;
    logic [DWELL_W-1:0] r_dwell;
    logic [NUM_CH-1:0]  r_mask;
    logic               r_sel_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_first_dir;
    logic [NUM_CH-1:0]  w_first_mask;
    logic [CODE_W-1:0]  w_first_cur;
    logic [CODE_W-1:0]  w_first_code;
    logic               w_first_found;
    logic [CODE_W-1:0]  w_next_code;
    logic               w_next_found;

    // First-channel lookup uses live inputs in IDLE and the latched config for wrap.
    assign w_first_dir  = (r_state == IDLE) ? dir : r_dir;
    assign w_first_mask = (r_state == IDLE) ? skip_mask : r_mask;
    assign w_first_cur  = w_first_dir ? FIRST_DN : FIRST_UP;

    sel_next_finder u_first (
        .i_cur   (w_first_cur),
        .i_dir   (w_first_dir),
        .i_mask  (w_first_mask),
        .i_incl  (1'b1),
        .o_code  (w_first_code),
        .o_found (w_first_found)
    );

    sel_next_finder u_next (
        .i_cur   (r_code),
        .i_dir   (r_dir),
        .i_mask  (r_mask),
        .i_incl  (1'b0),
        .o_code  (w_next_code),
        .o_found (w_next_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_dir       <= 1'b0;
            r_dwell     <= '0;
            r_mask      <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && !stop) begin
                        r_mode  <= mode;
                        r_dir   <= dir;
                        r_dwell <= dwell;
                        r_mask  <= skip_mask;
                        r_cnt   <= '0;
                        if (w_first_found) begin
                            r_code      <= w_first_code;
                            r_sel_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= SCAN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                SCAN: begin
                    if (stop) begin
                        r_sel_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else if (r_cnt == r_dwell) begin
                        r_cnt <= '0;
                        if (w_next_found) begin
                            r_code <= w_next_code;
                        end else if (r_mode) begin
                            r_code <= w_first_code;
                        end else begin
                            r_sel_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + DWELL_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_sel_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign a         = r_code[2];
    assign b         = r_code[1];
    assign c         = r_code[0];
    assign sel_valid = r_sel_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
